fft_frame_capture: RTL and testbench

FFT_FRAME_CAPTURE -- requirements
Module: fft_frame_capture

---
 rtl/fft_capture_pkg.sv | 21 ++
 rtl/fft_capture_ram.sv | 42 ++++
 rtl/fft_frame_capture.sv | 182 ++++++++++++++++++
 tb/tb_fft_frame_capture.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_capture_pkg
// Description : Shared types and default sizes for the FFT frame capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_capture_pkg;

    localparam int DEF_IWIDTH    = 21;
    localparam int DEF_LGSIZE    = 9;
    localparam int DEF_PWR_SHIFT = 10;
    localparam int NBINS         = 2 ** (DEF_LGSIZE - 1);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        CAPTURE   = 2'd1,
        SKIP      = 2'd2
    } capture_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_capture_ram.sv
`default_nettype none
// ============================================================================
// Module      : fft_capture_ram
// Description : Simple dual-port RAM, address = {bank, bin}, 1-cycle registered
//               read with resettable output register (contents not cleared).
// Revision    : 1.0 - initial release
// ============================================================================
module fft_capture_ram #(
    parameter int DW = 42,
    parameter int AW = 9
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fft_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_capture
// Description : Captures the lower half of each FFT frame into a ping-pong RAM
//               and publishes complete frames to a reader with ack handshake.
//               Define FFT_CAPTURE_POWER_EN to store (re^2+im^2)>>PWR_SHIFT.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_capture
    import fft_capture_pkg::*;
#(
    parameter int IWIDTH    = DEF_IWIDTH,
    parameter int LGSIZE    = DEF_LGSIZE,
    parameter int PWR_SHIFT = DEF_PWR_SHIFT,
`ifdef FFT_CAPTURE_POWER_EN
    localparam int DW = 32
`else
    localparam int DW = 2 * IWIDTH
`endif
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_ce,
    input  logic [2*IWIDTH-1:0] i_result,
    input  logic                i_sync,
    input  logic                i_rd_en,
    input  logic [LGSIZE-2:0]   i_rd_addr,
    input  logic                i_ack,
    output logic [DW-1:0]       o_rd_data,
    output logic                o_rd_valid,
    output logic                o_frame_ready,
    output logic [7:0]          o_drop_cnt
);

    localparam int NB = 2 ** (LGSIZE - 1);

    capture_state_t    r_state, w_state_next;
    logic [LGSIZE-1:0] r_cnt, w_cnt_next;
    logic              w_start, w_s0_we, w_s0_last;
    logic [LGSIZE-2:0] w_s0_bin;
    logic [DW-1:0]     w_s0_data;

    logic              w_we, w_last;
    logic [LGSIZE-2:0] w_bin;
    logic [DW-1:0]     w_wdata;

    logic              r_wb, r_rb, r_frame_ready, r_rd_valid;
    logic [7:0]        r_drop_cnt;

    assign w_start  = i_ce && i_sync;
    assign w_s0_bin = w_start ? '0 : r_cnt[LGSIZE-2:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= WAIT_SYNC;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // A qualified sync restarts capture from any state, dropping a partial frame.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_s0_we      = 1'b0;
        w_s0_last    = 1'b0;
        if (w_start) begin
            w_state_next = CAPTURE;
            w_cnt_next   = LGSIZE'(1);
            w_s0_we      = 1'b1;
        end else if (i_ce) begin
            case (r_state)
                CAPTURE: begin
                    w_s0_we    = 1'b1;
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == LGSIZE'(NB - 1)) begin
                        w_s0_last    = 1'b1;
                        w_state_next = SKIP;
                    end
                end
                SKIP: begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        w_state_next = WAIT_SYNC;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FFT_CAPTURE_POWER_EN
    localparam int PW = 2 * IWIDTH + 1;

    logic signed [IWIDTH-1:0]   w_re, w_im;
    logic signed [2*IWIDTH-1:0] w_re_sq, w_im_sq;
    logic [PW-1:0]              w_pwr, w_pwr_sh;
    logic                       r_p_we, r_p_last;
    logic [LGSIZE-2:0]          r_p_bin;
    logic [DW-1:0]              r_p_data;

    assign w_re     = i_result[2*IWIDTH-1:IWIDTH];
    assign w_im     = i_result[IWIDTH-1:0];
    assign w_re_sq  = (2*IWIDTH)'(w_re) * (2*IWIDTH)'(w_re);
    assign w_im_sq  = (2*IWIDTH)'(w_im) * (2*IWIDTH)'(w_im);
    // Squares are non-negative, so zero-extension gives the exact unsigned sum.
    assign w_pwr    = {1'b0, w_re_sq} + {1'b0, w_im_sq};
    assign w_pwr_sh = w_pwr >> PWR_SHIFT;
    assign w_s0_data = (w_pwr_sh > PW'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : w_pwr_sh[31:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_p_we   <= 1'b0;
            r_p_last <= 1'b0;
            r_p_bin  <= '0;
            r_p_data <= '0;
        end else begin
            r_p_we   <= w_s0_we;
            r_p_last <= w_s0_last;
            r_p_bin  <= w_s0_bin;
            r_p_data <= w_s0_data;
        end
    end

    assign w_we    = r_p_we;
    assign w_last  = r_p_last;
    assign w_bin   = r_p_bin;
    assign w_wdata = r_p_data;
`else
    assign w_s0_data = i_result;
    assign w_we      = w_s0_we;
    assign w_last    = w_s0_last;
    assign w_bin     = w_s0_bin;
    assign w_wdata   = w_s0_data;
`endif

    // Bank selection is taken at write time so a publish never lands in rb.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wb          <= 1'b0;
            r_rb          <= 1'b1;
            r_frame_ready <= 1'b0;
            r_drop_cnt    <= '0;
            r_rd_valid    <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (w_last) begin
                if (!r_frame_ready || i_ack) begin
                    r_rb          <= r_wb;
                    r_wb          <= ~r_wb;
                    r_frame_ready <= 1'b1;
                end else if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end else if (i_ack) begin
                r_frame_ready <= 1'b0;
            end
        end
    end

    fft_capture_ram #(
        .DW (DW),
        .AW (LGSIZE)
    ) u_ram (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (w_we),
        .i_waddr ({r_wb, w_bin}),
        .i_wdata (w_wdata),
        .i_re    (i_rd_en),
        .i_raddr ({r_rb, i_rd_addr}),
        .o_rdata (o_rd_data)
    );

    assign o_rd_valid    = r_rd_valid;
    assign o_frame_ready = r_frame_ready;
    assign o_drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_capture
// Description : Directed self-checking bench with a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_capture;

    localparam int IWIDTH    = 21;
    localparam int LGSIZE    = 9;
    localparam int PWR_SHIFT = 10;
    localparam int NB        = 256;
`ifdef FFT_CAPTURE_POWER_EN
    localparam int DW      = 32;
    localparam int PUB_LAT = 1;
`else
    localparam int DW      = 2 * IWIDTH;
    localparam int PUB_LAT = 0;
`endif

    logic                i_clk = 1'b0;
    logic                i_reset, i_ce, i_sync, i_rd_en, i_ack;
    logic [2*IWIDTH-1:0] i_result;
    logic [LGSIZE-2:0]   i_rd_addr;
    logic [DW-1:0]       o_rd_data;
    logic                o_rd_valid, o_frame_ready;
    logic [7:0]          o_drop_cnt;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] sb_q[$];
    int            m_pub;
    bit            m_ready;
    int            m_drop;

    fft_frame_capture #(
        .IWIDTH    (IWIDTH),
        .LGSIZE    (LGSIZE),
        .PWR_SHIFT (PWR_SHIFT)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_ce          (i_ce),
        .i_result      (i_result),
        .i_sync        (i_sync),
        .i_rd_en       (i_rd_en),
        .i_rd_addr     (i_rd_addr),
        .i_ack         (i_ack),
        .o_rd_data     (o_rd_data),
        .o_rd_valid    (o_rd_valid),
        .o_frame_ready (o_frame_ready),
        .o_drop_cnt    (o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [2*IWIDTH-1:0] mk(input int f, input int k);
        logic [IWIDTH-1:0] re, im;
        re = IWIDTH'(k + 300 * f);
        im = IWIDTH'(-k - 7 * f);
        return {re, im};
    endfunction

    function automatic logic [DW-1:0] expw(input int f, input int k);
`ifdef FFT_CAPTURE_POWER_EN
        longint re, im, p;
        re = longint'(k + 300 * f);
        im = longint'(-k - 7 * f);
        p  = (re * re + im * im) >>> PWR_SHIFT;
        if (p > 64'sh0_FFFF_FFFF) p = 64'sh0_FFFF_FFFF;
        return DW'(p);
`else
        return mk(f, k);
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic read_exp(input int addr, input logic [DW-1:0] exp);
        i_rd_en   = 1'b1;
        i_rd_addr = (LGSIZE-1)'(addr);
        sb_q.push_back(exp);
        tick();
        i_rd_en = 1'b0;
    endtask

    task automatic read(input int addr);
        read_exp(addr, expw(m_pub, addr));
    endtask

    task automatic do_ack();
        i_ack = 1'b1;
        tick();
        i_ack   = 1'b0;
        m_ready = 1'b0;
        check("ack_clears_ready", 64'(o_frame_ready), 64'(m_ready));
    endtask

    // Streams bins of frame f; the model publishes or drops on frame completion.
    task automatic send_bins(input int f, input int nbins, input bit sync0, input int ack_idx);
        bit done, ack;
        for (int k = 0; k < nbins; k++) begin
            i_ce     = 1'b1;
            i_sync   = sync0 && (k == 0);
            i_result = mk(f, k);
            i_ack    = (k == ack_idx);
            tick();
            done = sync0 && (k == NB - 1 + PUB_LAT);
            ack  = (k == ack_idx);
            if (done) begin
                if (!m_ready || ack) begin
                    m_ready = 1'b1;
                    m_pub   = f;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end else if (ack) begin
                m_ready = 1'b0;
            end
            check("frame_ready", 64'(o_frame_ready), 64'(m_ready));
            if (done) check("drop_cnt", 64'(o_drop_cnt), 64'(m_drop));
        end
        i_ce   = 1'b0;
        i_sync = 1'b0;
        i_ack  = 1'b0;
    endtask

    always @(negedge i_clk) begin
        if (o_rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("rd_unexpected", 64'(o_rd_valid), 64'd0);
            end else begin
                check("rd_data", 64'(o_rd_data), 64'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        i_reset = 1'b0; i_ce = 1'b0; i_sync = 1'b0; i_rd_en = 1'b0; i_ack = 1'b0;
        i_result = '0; i_rd_addr = '0;
        m_pub = -1; m_ready = 1'b0; m_drop = 0;

        #2 i_reset = 1'b1;
        #1;
        check("rst_frame_ready", 64'(o_frame_ready), 64'd0);
        check("rst_rd_valid",    64'(o_rd_valid),    64'd0);
        check("rst_drop_cnt",    64'(o_drop_cnt),    64'd0);
        check("rst_rd_data",     64'(o_rd_data),     64'd0);
        tick();
        tick();
        i_reset = 1'b0;

        // Samples without sync are ignored.
        send_bins(99, 10, 1'b0, -1);

        // First frame: publish after bin 255, raw readback.
        send_bins(0, 512, 1'b1, -1);
`ifdef FFT_CAPTURE_POWER_EN
        read(7);
`else
        read_exp(7, 42'h0FFFFF9);
`endif
        read(0);
        read(255);
        read(128);

        // Second frame without ack is dropped; frame 0 still visible.
        send_bins(1, 512, 1'b1, -1);
        read(7);
        read(200);

        // Ack then third frame gets published.
        do_ack();
        send_bins(2, 512, 1'b1, -1);
        read(7);
        read(100);

        // Ack coincident with completion: publish, no drop.
        send_bins(3, 512, 1'b1, NB - 1 + PUB_LAT);
        read(7);
        read(255);

        // Restart at bin 100: nothing at the old bin 255, publish 256 bins later.
        do_ack();
        send_bins(4, 101, 1'b1, -1);
        send_bins(5, 512, 1'b1, -1);
        read(7);
        read(50);
        read(3);

        // Reset in the middle of a capture.
        send_bins(6, 200, 1'b1, -1);
        i_ce     = 1'b1;
        i_result = mk(6, 200);
        #2 i_reset = 1'b1;
        #1;
        m_ready = 1'b0;
        m_drop  = 0;
        check("midrst_frame_ready", 64'(o_frame_ready), 64'd0);
        check("midrst_drop_cnt",    64'(o_drop_cnt),    64'd0);
        check("midrst_rd_data",     64'(o_rd_data),     64'd0);
        check("midrst_rd_valid",    64'(o_rd_valid),    64'd0);
        i_ce = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;

        send_bins(98, 300, 1'b0, -1);
        send_bins(7, 512, 1'b1, -1);
        read(7);
        read(255);

        tick();
        tick();
        check("rd_missing", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
